// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp encodings, FSM states,
// default cycle counts and small decode helpers.
// Optional feature macro: MD_UNIT_MADD_EN (MDOp 111 = signed multiply-accumulate).
package md_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_MADD  = 3'b111
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // A zero-length operation makes no sense for the handshake; clamp to one cycle.
  function automatic int unsigned eff_cycles(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/result bundle of the multiply/divide unit.
// master drives the request (A, B, MDOp, Start); slave returns Busy, HI and LO.
interface md_unit_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A, B, MDOp, Start, input Busy, HI, LO);
  modport slave  (input A, B, MDOp, Start, output Busy, HI, LO);
endinterface

// File: rtl/md_core.sv
// Combinational result datapath for the multiply/divide unit.
// One shared 64-bit multiplier and one shared 32-bit divider; signed variants
// are handled by sign-extension (multiply) and magnitude/sign fix-up (divide).
// Optional feature macro: MD_UNIT_MADD_EN.
module md_core
  import md_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  md_op_e      op,
  input  logic [63:0] acc,
  output logic [63:0] result,
  output logic        wr_en
);

  logic        sgn_mul;
  logic        sgn_div;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] q_raw;
  logic [31:0] r_raw;
  logic [31:0] quo;
  logic [31:0] rem;

  assign sgn_mul = (op == OP_MULT) || (op == OP_MADD);
  assign sgn_div = (op == OP_DIV);

  // Low 64 bits of the product of the sign/zero-extended operands equal the
  // exact signed or unsigned product.
  assign prod = {{32{sgn_mul & a[31]}}, a} * {{32{sgn_mul & b[31]}}, b};

  // Signed divide runs on magnitudes; 0x80000000 has magnitude 0x80000000 as an
  // unsigned value, so the overflow case falls out as quotient 0x80000000, rem 0.
  assign a_neg = sgn_div & a[31];
  assign b_neg = sgn_div & b[31];
  assign dvd   = a_neg ? (~a + 32'd1) : a;
  assign dvs   = (b == 32'd0) ? 32'd1 : (b_neg ? (~b + 32'd1) : b);
  assign q_raw = dvd / dvs;
  assign r_raw = dvd % dvs;
  assign quo   = (a_neg ^ b_neg) ? (~q_raw + 32'd1) : q_raw;
  assign rem   = a_neg ? (~r_raw + 32'd1) : r_raw;

  // Select the result for the captured op; divide by zero suppresses the write.
  always_comb begin
    result = acc;
    wr_en  = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: begin
        result = prod;
        wr_en  = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        result = {rem, quo};
        wr_en  = (b != 32'd0);
      end
`ifdef MD_UNIT_MADD_EN
      OP_MADD: begin
        result = acc + prod;
        wr_en  = 1'b1;
      end
`endif
      default: begin
        result = acc;
        wr_en  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Operands and op are captured on Start, a down-counter times the operation and
// the result commits on the terminal count. MTHI/MTLO write directly from IDLE.
// Optional feature macro: MD_UNIT_MADD_EN (MDOp 111 = MADD; otherwise 111 = none).
//
// state   | meaning
// ST_IDLE | waiting for Start; MTHI/MTLO handled here in one cycle
// ST_RUN  | multi-cycle op in flight, Busy high, HI/LO held until commit
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  md_unit_if.slave   bus
);

  localparam int unsigned MULT_N = eff_cycles(MULT_CYCLES);
  localparam int unsigned DIV_N  = eff_cycles(DIV_CYCLES);

  md_state_e   state_q;
  logic [31:0] cnt_q;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  md_op_e      op_q;

  md_op_e      op_in;
  logic        is_long;
  logic [63:0] res;
  logic        res_we;

  // Decode the incoming op; MADD collapses to no-op when not built in.
  always_comb begin
    op_in = md_op_e'(bus.MDOp);
`ifndef MD_UNIT_MADD_EN
    if (op_in == OP_MADD) op_in = OP_NONE;
`endif
    is_long = (op_in == OP_MULT) || (op_in == OP_MULTU) ||
              (op_in == OP_DIV)  || (op_in == OP_DIVU)  ||
              (op_in == OP_MADD);
  end

  md_core u_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .acc    ({hi_q, lo_q}),
    .result (res),
    .wr_en  (res_we)
  );

  // FSM, operation timer, operand capture and HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.Start) begin
            if (is_long) begin
              a_q     <= bus.A;
              b_q     <= bus.B;
              op_q    <= op_in;
              cnt_q   <= is_div_op(op_in) ? 32'(DIV_N) : 32'(MULT_N);
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end else if (op_in == OP_MTHI) begin
              hi_q <= bus.A;
            end else if (op_in == OP_MTLO) begin
              lo_q <= bus.A;
            end
          end
        end
        ST_RUN: begin
          if (cnt_q == 32'd1) begin
            if (res_we) begin
              hi_q <= res[63:32];
              lo_q <= res[31:0];
            end
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            op_q    <= OP_NONE;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases for the documented examples
// plus randomized ops compared with a plain-arithmetic reference of HI/LO.
// Optional feature macro: MD_UNIT_MADD_EN (bench expectations follow it).
module tb_md_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;
  localparam int MC_EFF = (MC == 0) ? 1 : int'(MC);
  localparam int DC_EFF = (DC == 0) ? 1 : int'(DC);

  logic clk;
  logic rst_n;
  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi     = '0;
  logic [31:0] m_lo     = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_cycles(input logic [2:0] op);
    case (op)
      3'd1, 3'd2: return MC_EFF;
      3'd3, 3'd4: return DC_EFF;
`ifdef MD_UNIT_MADD_EN
      3'd7:       return MC_EFF;
`endif
      default:    return 0;
    endcase
  endfunction

  // Reference: new HI/LO straight from the arithmetic definition of each op.
  task automatic ref_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd3: if (b != 0) begin
              q = sa / sb; r = sa % sb;
              m_lo = q[31:0]; m_hi = r[31:0];
            end
      3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
`ifdef MD_UNIT_MADD_EN
      3'd7: begin p = {m_hi, m_lo} + 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
`endif
      default: ;
    endcase
  endtask

  // Issue one op; optionally fire a second Start mid-run, which must be ignored.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit inject, input logic [2:0] iop, input logic [31:0] ia);
    int n, cnt;
    n = ref_cycles(op);
    @(negedge clk);
    bus.Start = 1'b1; bus.MDOp = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.Start = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.MDOp = 3'($urandom);
    if (n > 0) begin
      cnt = 0;
      while (bus.Busy === 1'b1 && cnt < 64) begin
        cnt++;
        chk("run_hi_hold", bus.HI, m_hi);
        chk("run_lo_hold", bus.LO, m_lo);
        if (inject && cnt == 2) begin
          bus.Start = 1'b1; bus.MDOp = iop; bus.A = ia;
        end
        @(negedge clk);
        bus.Start = 1'b0;
      end
      chk("busy_cycles", cnt, n);
    end else begin
      chk("no_busy", bus.Busy, 1'b0);
    end
    ref_apply(op, a, b);
    chk("hi", bus.HI, m_hi);
    chk("lo", bus.LO, m_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op, iop;
    logic [31:0] a, b;
    rst_n = 1'b0;
    bus.Start = 1'b0; bus.MDOp = 3'd0; bus.A = '0; bus.B = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.Busy, 1'b0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    rst_n = 1'b1;

    do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0, 3'd0, 0);
    chk("mult_hi_c", bus.HI, 32'hFFFF_FFFF);
    chk("mult_lo_c", bus.LO, 32'hFFFF_FFFE);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 3'd0, 0);
    chk("multu_hi_c", bus.HI, 32'd1);
    chk("multu_lo_c", bus.LO, 32'hFFFF_FFFE);
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 3'd0, 0);
    chk("div_lo_c", bus.LO, 32'hFFFF_FFFD);
    chk("div_hi_c", bus.HI, 32'hFFFF_FFFF);
    do_op(3'd4, 32'd7, 32'd2, 0, 3'd0, 0);
    chk("divu_lo_c", bus.LO, 32'd3);
    chk("divu_hi_c", bus.HI, 32'd1);

    do_op(3'd5, 32'd5, 32'd0, 0, 3'd0, 0);
    do_op(3'd6, 32'd6, 32'd0, 0, 3'd0, 0);
    do_op(3'd3, 32'd1234, 32'd0, 0, 3'd0, 0);
    chk("div0_hi_c", bus.HI, 32'd5);
    chk("div0_lo_c", bus.LO, 32'd6);
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd0, 0);
    chk("divovf_lo_c", bus.LO, 32'h8000_0000);
    chk("divovf_hi_c", bus.HI, 32'd0);

    do_op(3'd4, 32'd100, 32'd7, 1, 3'd6, 32'h1234);
    chk("mtlo_busy_c", bus.LO, 32'd14);
    do_op(3'd6, 32'h1234, 32'd0, 0, 3'd0, 0);
    chk("mtlo_idle_c", bus.LO, 32'h1234);

    // Abort a MULT mid-flight with an asynchronous reset.
    do_op(3'd5, 32'hDEAD, 32'd0, 0, 3'd0, 0);
    @(negedge clk);
    bus.Start = 1'b1; bus.MDOp = 3'd1; bus.A = 32'd3; bus.B = 32'd4;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.Busy, 1'b0);
    chk("abort_hi", bus.HI, 32'd0);
    chk("abort_lo", bus.LO, 32'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (MC_EFF + 3) @(negedge clk);
    chk("abort_nocommit_busy", bus.Busy, 1'b0);
    chk("abort_nocommit_hi", bus.HI, 32'd0);
    chk("abort_nocommit_lo", bus.LO, 32'd0);

    do_op(3'd5, 32'd0, 32'd0, 0, 3'd0, 0);
    do_op(3'd6, 32'hFFFF_FFFF, 32'd0, 0, 3'd0, 0);
    do_op(3'd7, 32'd1, 32'd1, 0, 3'd0, 0);
`ifdef MD_UNIT_MADD_EN
    chk("madd_hi_c", bus.HI, 32'd1);
    chk("madd_lo_c", bus.LO, 32'd0);
`else
    chk("madd_off_hi_c", bus.HI, 32'd0);
    chk("madd_off_lo_c", bus.LO, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      iop = 3'($urandom_range(0, 7));
      do_op(op, a, b, ($urandom_range(0, 3) == 0), iop, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, giving the busy cycles for multiply operations.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, giving the busy cycles for divide operations.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: A  input  32  operand 1 (dividend, multiplicand, MTHI/MTLO data).
REQ-007 Port: B  input  32  operand 2 (divisor, multiplier).
REQ-008 Port: MDOp  input  3  operation: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 MADD (only when configured in).
REQ-009 Port: Start  input  1  single-cycle request strobe, sampled with MDOp, A and B.
REQ-010 Port: Busy  output  1  a multi-cycle operation is in progress.
REQ-011 Port: HI  output  32  HI register.
REQ-012 Port: LO  output  32  LO register.

Function
REQ-013 States SHALL be IDLE and RUN; IDLE->RUN on Start with MULT/MULTU/DIV/DIVU/MADD; RUN->IDLE when the counter expires.
REQ-014 On entry to RUN, A, B and MDOp SHALL be captured; later input changes SHALL NOT affect the result.
REQ-015 Busy SHALL be high from cycle t+1 through t+N, where t is the Start cycle and N is MULT_CYCLES or DIV_CYCLES.
REQ-016 HI/LO SHALL keep their old values during RUN and SHALL update on the clock edge that ends cycle t+N, so they are visible with Busy low at t+N+1.
REQ-017 MULT/MULTU SHALL write the {HI,LO} 64-bit signed/unsigned product.
REQ-018 DIV/DIVU SHALL write LO=quotient and HI=remainder; signed division truncates toward zero and the remainder takes the dividend's sign.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0.
REQ-020 A divisor of 0 SHALL still run DIV_CYCLES and SHALL leave HI/LO unchanged.
REQ-021 MTHI/MTLO with Start in IDLE SHALL write A to HI/LO at the next edge with no Busy cycle.
REQ-022 Start while Busy SHALL be ignored for every MDOp; Start with MDOp=000 SHALL be ignored.
REQ-023 With MULT_CYCLES or DIV_CYCLES set to 0, a value of 1 SHALL be used.

Reset
REQ-024 rst_n low SHALL asynchronously force HI=0, LO=0, Busy=0, counter=0 and state IDLE.
REQ-025 Reset during RUN SHALL abort the operation and discard the captured result.
REQ-026 Start SHALL be honoured from the first rising edge after rst_n is released.

Configuration
REQ-027 Macro MD_UNIT_MADD_EN defined: MDOp 111 = MADD, which adds the signed A*B to {HI,LO} modulo 2^64 with MULT_CYCLES latency; the accumulator value is read at commit.
REQ-028 Macro MD_UNIT_MADD_EN undefined: MDOp 111 SHALL be treated as 000.

Structure
REQ-029 Package md_pkg SHALL hold the MDOp encodings, the state enum and the default cycle counts.
REQ-030 Combinational result computation SHALL live in sub-module md_core (inputs: captured operands and op; outputs: 64-bit result and write-enable); md_unit holds the FSM, counter and HI/LO.

Verification
REQ-031 MULT A=0xFFFFFFFF, B=2 -> Busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU with the same operands -> HI=1, LO=0xFFFFFFFE.
REQ-032 DIV A=-7 (0xFFFFFFF9), B=2 -> Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=2 -> LO=3, HI=1.
REQ-033 HI=5, LO=6, then DIV with B=0 -> Busy for 10 cycles, then HI=5, LO=6 unchanged; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 MTLO A=0x1234 while Busy -> LO unchanged; MTLO A=0x1234 in IDLE -> LO=0x1234 next cycle, Busy stays 0.
REQ-035 rst_n pulsed low at cycle 3 of a MULT -> HI=LO=0 and Busy=0 immediately; no later commit occurs.
REQ-036 With MD_UNIT_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADD A=1, B=1 -> HI=1, LO=0; without the macro, the same stimulus leaves HI/LO unchanged and Busy low.
